// File: rtl/linebuffer_seq.sv
// linebuffer_seq: trims capture lines to line_len, counts lines per frame,
// optionally appends a zero flush line (macro LINEBUFFER_SEQ_FLUSH_EN).
// Ports: clk, rst (async high); vsync_i/de_i/data_i from capture;
//   line_len_i/num_lines_i config; lb_vsync_o/lb_de_o/lb_data_o to line
//   buffer; busy_o, frame_done_o (pulse), line_err_o (sticky), line_count_o.
module linebuffer_seq #(
  parameter int DATA_WIDTH      = 10,
  parameter int MAX_DATA_LENGTH = 1024,
  parameter int MAX_LINES       = 1024,
  parameter int FLUSH_GAP       = 16,
  localparam int LW = $clog2(MAX_DATA_LENGTH + 1),
  localparam int VW = $clog2(MAX_LINES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [LW-1:0]         line_len_i,
  input  logic [VW-1:0]         num_lines_i,
  output logic                  lb_vsync_o,
  output logic                  lb_de_o,
  output logic [DATA_WIDTH-1:0] lb_data_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  line_err_o,
  output logic [VW-1:0]         line_count_o
);

  localparam int GW = $clog2(FLUSH_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(FLUSH_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic                  armed_q, armed_d;
  logic [LW-1:0]         len_q, len_d;
  logic [VW-1:0]         nl_q, nl_d;
  logic [LW-1:0]         pc_q, pc_d;
  logic [VW-1:0]         lcnt_q, lcnt_d;
  logic                  dep_q, dep_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [LW-1:0]         fl_q, fl_d;
  logic                  vs_q, vs_d;
  logic                  de_q, de_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [VW-1:0]         lcnt_inc;

  assign lcnt_inc = lcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    len_d   = len_q;
    nl_d    = nl_q;
    pc_d    = pc_q;
    lcnt_d  = lcnt_q;
    dep_d   = 1'b0;
    gap_d   = gap_q;
    fl_d    = fl_q;
    vs_d    = vsync_i;
    de_d    = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (vsync_i) begin
      state_d = S_IDLE;
      armed_d = 1'b1;
      pc_d    = '0;
      lcnt_d  = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            armed_d = 1'b0;
            len_d   = line_len_i;
            nl_d    = num_lines_i;
            pc_d    = '0;
            if (line_len_i == '0 || num_lines_i == '0)
              err_d = 1'b1;
            else
              state_d = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          // dep tracks de only while ACTIVE so entry never fakes a fall
          dep_d = de_i;
          if (de_i) begin
            pc_d = pc_q + 1'b1;
            if (pc_q < len_q) begin
              de_d   = 1'b1;
              data_d = data_i;
            end
          end else if (dep_q) begin
            if (pc_q != len_q)
              err_d = 1'b1;
            lcnt_d = lcnt_inc;
            pc_d   = '0;
            if (lcnt_inc == nl_q) begin
`ifdef LINEBUFFER_SEQ_FLUSH_EN
              state_d = S_GAP;
              gap_d   = '0;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
`endif
            end
          end
        end
        S_GAP: begin
          // last gap cycle already launches the first flush pixel
          if (gap_q == GAP_LAST) begin
            state_d = S_FLUSH;
            de_d    = 1'b1;
            data_d  = '0;
            fl_d    = LW'(1);
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_FLUSH: begin
          if (fl_q == len_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            fl_d   = fl_q + 1'b1;
            de_d   = 1'b1;
            data_d = '0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d == S_ACTIVE) || (state_d == S_GAP) ||
             (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      len_q   <= '0;
      nl_q    <= '0;
      pc_q    <= '0;
      lcnt_q  <= '0;
      dep_q   <= 1'b0;
      gap_q   <= '0;
      fl_q    <= '0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      len_q   <= len_d;
      nl_q    <= nl_d;
      pc_q    <= pc_d;
      lcnt_q  <= lcnt_d;
      dep_q   <= dep_d;
      gap_q   <= gap_d;
      fl_q    <= fl_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign lb_vsync_o   = vs_q;
  assign lb_de_o      = de_q;
  assign lb_data_o    = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign line_err_o   = err_q;
  assign line_count_o = lcnt_q;

endmodule

// File: tb/tb_linebuffer_seq.sv
// tb_linebuffer_seq: directed checks of linebuffer_seq with line_len=8,
// num_lines=4, FLUSH_GAP=4; flush checks follow LINEBUFFER_SEQ_FLUSH_EN.
module tb_linebuffer_seq;

  logic        clk;
  logic        rst;
  logic        vsync_i;
  logic        de_i;
  logic [9:0]  data_i;
  logic [10:0] line_len_i;
  logic [10:0] num_lines_i;
  logic        lb_vsync_o;
  logic        lb_de_o;
  logic [9:0]  lb_data_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        line_err_o;
  logic [10:0] line_count_o;

  int total;
  int bad;
  int pv;

  linebuffer_seq #(
    .DATA_WIDTH(10),
    .MAX_DATA_LENGTH(1024),
    .MAX_LINES(1024),
    .FLUSH_GAP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vsync_i(vsync_i),
    .de_i(de_i),
    .data_i(data_i),
    .line_len_i(line_len_i),
    .num_lines_i(num_lines_i),
    .lb_vsync_o(lb_vsync_o),
    .lb_de_o(lb_de_o),
    .lb_data_o(lb_data_o),
    .busy_o(busy_o),
    .frame_done_o(frame_done_o),
    .line_err_o(line_err_o),
    .line_count_o(line_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit vs;
    int npix;
    int fwd;
    bit err;
    int cnt;
    bit last;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp_v);
    end
  endtask

  task automatic cyc(input logic v, input logic d, input logic [9:0] x);
    @(negedge clk);
    vsync_i = v;
    de_i    = d;
    data_i  = x;
    @(posedge clk);
    #1;
  endtask

  task automatic do_vsync(input bit ok);
    cyc(1'b1, 1'b0, 10'd0);
    chk("vs_lbvs", int'(lb_vsync_o), 1);
    chk("vs_cnt", int'(line_count_o), 0);
    chk("vs_err", int'(line_err_o), 0);
    chk("vs_busy", int'(busy_o), 0);
    chk("vs_de", int'(lb_de_o), 0);
    chk("vs_done", int'(frame_done_o), 0);
    cyc(1'b0, 1'b0, 10'd0);
    chk("vs_lbvs0", int'(lb_vsync_o), 0);
    chk("start_busy", int'(busy_o), ok ? 1 : 0);
    chk("start_err", int'(line_err_o), ok ? 0 : 1);
    pv = 0;
  endtask

  task automatic end_frame(input bit err);
`ifdef LINEBUFFER_SEQ_FLUSH_EN
    chk("gap_busy", int'(busy_o), 1);
    chk("gap_done", int'(frame_done_o), 0);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 1'b0, 10'd0);
      chk("gap_de", int'(lb_de_o), 0);
    end
    for (int j = 0; j < 8; j++) begin
      cyc(1'b0, 1'b0, 10'd0);
      chk("fl_de", int'(lb_de_o), 1);
      chk("fl_data", int'(lb_data_o), 0);
      chk("fl_done", int'(frame_done_o), 0);
    end
    cyc(1'b0, 1'b0, 10'd0);
    chk("fl_end_de", int'(lb_de_o), 0);
`endif
    chk("done_pulse", int'(frame_done_o), 1);
    chk("done_busy", int'(busy_o), 0);
    chk("done_err", int'(line_err_o), err ? 1 : 0);
    cyc(1'b0, 1'b0, 10'd0);
    chk("done_clr", int'(frame_done_o), 0);
    chk("done_cnt", int'(line_count_o), 4);
  endtask

  task automatic run_line(input int npix, input int fwd, input bit err,
                          input int cnt, input bit last);
    int held;
    held = 0;
    for (int i = 0; i < npix; i++) begin
      cyc(1'b0, 1'b1, 10'(pv));
      if (i < fwd) begin
        chk("px_de", int'(lb_de_o), 1);
        chk("px_data", int'(lb_data_o), pv);
        held = pv;
      end else begin
        chk("drop_de", int'(lb_de_o), 0);
        chk("drop_hold", int'(lb_data_o), held);
      end
      pv++;
    end
    cyc(1'b0, 1'b0, 10'd0);
    chk("fall_de", int'(lb_de_o), 0);
    chk("line_cnt", int'(line_count_o), cnt);
    chk("line_err", int'(line_err_o), err ? 1 : 0);
    if (last) begin
      end_frame(err);
    end else begin
      for (int j = 0; j < 2; j++) begin
        cyc(1'b0, 1'b0, 10'd0);
        chk("idle_de", int'(lb_de_o), 0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    pv = 0;
    tbl[0]  = '{1'b1, 8, 8, 1'b0, 1, 1'b0};
    tbl[1]  = '{1'b0, 8, 8, 1'b0, 2, 1'b0};
    tbl[2]  = '{1'b0, 8, 8, 1'b0, 3, 1'b0};
    tbl[3]  = '{1'b0, 8, 8, 1'b0, 4, 1'b1};
    tbl[4]  = '{1'b1, 8, 8, 1'b0, 1, 1'b0};
    tbl[5]  = '{1'b0, 10, 8, 1'b1, 2, 1'b0};
    tbl[6]  = '{1'b0, 8, 8, 1'b1, 3, 1'b0};
    tbl[7]  = '{1'b0, 8, 8, 1'b1, 4, 1'b1};
    tbl[8]  = '{1'b1, 8, 8, 1'b0, 1, 1'b0};
    tbl[9]  = '{1'b0, 8, 8, 1'b0, 2, 1'b0};
    tbl[10] = '{1'b0, 6, 6, 1'b1, 3, 1'b0};
    tbl[11] = '{1'b0, 8, 8, 1'b1, 4, 1'b1};

    rst = 1'b0;
    vsync_i = 1'b0;
    de_i = 1'b0;
    data_i = '0;
    line_len_i = 11'd8;
    num_lines_i = 11'd4;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_de", int'(lb_de_o), 0);
    chk("rst_vs", int'(lb_vsync_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(frame_done_o), 0);
    chk("rst_err", int'(line_err_o), 0);
    chk("rst_cnt", int'(line_count_o), 0);
    @(negedge clk);
    rst = 1'b0;

    do_vsync(1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 10'(100 + i));
    chk("pre_rst_de", int'(lb_de_o), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_de", int'(lb_de_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_data", int'(lb_data_o), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 10'(200 + i));
      chk("unarmed_de", int'(lb_de_o), 0);
      chk("unarmed_busy", int'(busy_o), 0);
    end
    cyc(1'b0, 1'b0, 10'd0);
    chk("unarmed_cnt", int'(line_count_o), 0);

    for (int k = 0; k < 12; k++) begin
      if (tbl[k].vs) do_vsync(1'b1);
      run_line(tbl[k].npix, tbl[k].fwd, tbl[k].err, tbl[k].cnt, tbl[k].last);
    end

    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 10'(300 + i));
      chk("post_done_de", int'(lb_de_o), 0);
    end
    cyc(1'b0, 1'b0, 10'd0);
    chk("post_done_cnt", int'(line_count_o), 4);
    chk("post_done_pulse", int'(frame_done_o), 0);

    do_vsync(1'b1);
    run_line(8, 8, 1'b0, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 10'(pv));
      pv++;
    end
    chk("abort_pre_de", int'(lb_de_o), 1);
    cyc(1'b1, 1'b1, 10'd55);
    chk("abort_de", int'(lb_de_o), 0);
    chk("abort_cnt", int'(line_count_o), 0);
    chk("abort_done", int'(frame_done_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    cyc(1'b0, 1'b0, 10'd0);
    chk("abort_restart", int'(busy_o), 1);
    pv = 0;
    run_line(8, 8, 1'b0, 1, 1'b0);
    run_line(8, 8, 1'b0, 2, 1'b0);
    run_line(8, 8, 1'b0, 3, 1'b0);
    run_line(8, 8, 1'b0, 4, 1'b1);

    num_lines_i = 11'd0;
    do_vsync(1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 10'(400 + i));
      chk("bad_cfg_de", int'(lb_de_o), 0);
      chk("bad_cfg_busy", int'(busy_o), 0);
    end
    cyc(1'b0, 1'b0, 10'd0);
    chk("bad_cfg_cnt", int'(line_count_o), 0);
    chk("bad_cfg_err", int'(line_err_o), 1);
    num_lines_i = 11'd4;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
